appr_err_monitor: RTL and testbench

Result-side companion to `appr_wrapper`. It observes the operand stream fed to the approximate multiplier and the result returned `DUT_LATENCY` cycles later. It recomputes the exact signed product and accumulates error statistics over a programmed number of samples. It sits beside the multiplier in characterisation builds and exposes totals when a run completes.

---
 rtl/appr_mon_pkg.sv | 26 ++
 rtl/appr_delay_line.sv | 49 ++++
 rtl/appr_err_monitor.sv | 149 ++++++++++++++
 tb/tb_appr_err_monitor.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/appr_mon_pkg.sv
// Shared types, default widths and helpers for the approximate-multiplier
// error monitor.
package appr_mon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } mon_state_e;

  localparam int MAC_IN_WIDTH_DEF = 9;
  localparam int DUT_LATENCY_DEF  = 2;
  localparam int CNT_W_DEF        = 32;
  localparam int ACC_W_DEF        = 48;

  // Working width of abs_err; callers sign-extend into it and keep the low bits.
  localparam int ABS_W = 64;

  // Magnitude of a signed error. The most negative value cannot occur for a
  // properly sign-extended error, so the unsigned result always fits.
  function automatic logic [ABS_W-1:0] abs_err(input logic signed [ABS_W-1:0] e);
    return (e < 0) ? -e : e;
  endfunction

endpackage

// File: rtl/appr_delay_line.sv
// Shift register of {valid, data} entries. Valid bits are reset and
// clearable; data bits carry no reset since they are only used when valid.
module appr_delay_line #(
  parameter int DEPTH = 2,
  parameter int W     = 18
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         in_vld,
  input  logic [W-1:0] in_data,
  output logic         out_vld,
  output logic [W-1:0] out_data,
  output logic         any_vld
);

  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_in;
  logic [W-1:0]     data_q  [DEPTH];
  logic [W-1:0]     data_in [DEPTH];

  // Form the shifted-by-one view of every stage; stage 0 takes the new entry.
  always_comb begin
    vld_in     = '0;
    vld_in[0]  = in_vld;
    data_in[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      vld_in[i]  = vld_q[i-1];
      data_in[i] = data_q[i-1];
    end
  end

  // Valid bits: asynchronous reset plus synchronous clear at run start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      vld_q <= '0;
    else if (clr) vld_q <= '0;
    else          vld_q <= vld_in;
  end

  // Data payload shifts unconditionally alongside the valid bits.
  always_ff @(posedge clk) begin
    data_q <= data_in;
  end

  assign out_vld  = vld_q[DEPTH-1];
  assign out_data = data_q[DEPTH-1];
  assign any_vld  = |vld_q;

endmodule

// File: rtl/appr_err_monitor.sv
// Error-statistics monitor for the approximate multiplier: recomputes the
// exact product of each accepted operand pair, lines it up with the result
// returned DUT_LATENCY cycles later and accumulates count/mismatch/sum/max.
module appr_err_monitor
  import appr_mon_pkg::*;
#(
  parameter int MAC_IN_WIDTH = MAC_IN_WIDTH_DEF,
  parameter int DUT_LATENCY  = DUT_LATENCY_DEF,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int ACC_W        = ACC_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_i,
  input  logic [CNT_W-1:0]            n_samples_i,
  input  logic                        valid_i,
  input  logic [MAC_IN_WIDTH-1:0]     a_i,
  input  logic [MAC_IN_WIDTH-1:0]     b_i,
  input  logic [2*MAC_IN_WIDTH-1:0]   res_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [CNT_W-1:0]            sample_cnt_o,
  output logic [CNT_W-1:0]            mismatch_cnt_o,
  output logic [ACC_W-1:0]            err_sum_o,
  output logic [2*MAC_IN_WIDTH:0]     err_max_o
);

  localparam int MAC_OUT_WIDTH = 2 * MAC_IN_WIDTH;
  localparam int ERR_W         = MAC_OUT_WIDTH + 1;
  localparam int SUM_W         = ((ACC_W > ERR_W) ? ACC_W : ERR_W) + 1;
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  // Accumulate with clamp at all-ones; the sum is formed wide enough that
  // neither operand width can overflow before the compare.
  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                               input logic [ERR_W-1:0] inc);
    logic [SUM_W-1:0] s;
    s = SUM_W'(acc) + SUM_W'(inc);
    if (s > SUM_W'(ACC_MAX)) return ACC_MAX;
    return s[ACC_W-1:0];
  endfunction

  mon_state_e       state_q, state_d;
  logic [CNT_W-1:0] n_lat_q;
  logic [CNT_W-1:0] acc_cnt_q;
  logic             accept, last_acc, clr;
  logic             busy_d, done_d;

  logic signed [MAC_OUT_WIDTH-1:0] exact_p0;
  logic                            vld_p1;
  logic [MAC_OUT_WIDTH-1:0]        exact_p1;
  logic                            any_vld;
  logic signed [ERR_W-1:0]         res_ext_p1, exact_ext_p1, err_p1;
  logic [ABS_W-1:0]                abs_full_p1;
  logic [ERR_W-1:0]                err_mag_p1;
  logic [ABS_W-ERR_W-1:0]          unused_abs_hi;

  // ---- stage p0: operand acceptance and exact product ----
  assign exact_p0 = $signed(a_i) * $signed(b_i);

  appr_delay_line #(
    .DEPTH (DUT_LATENCY),
    .W     (MAC_OUT_WIDTH)
  ) u_dly (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .in_vld   (accept),
    .in_data  (exact_p0),
    .out_vld  (vld_p1),
    .out_data (exact_p1),
    .any_vld  (any_vld)
  );

  // ---- stage p1: delay-line tail meets the returned result ----
  assign res_ext_p1    = ERR_W'($signed(res_i));
  assign exact_ext_p1  = ERR_W'($signed(exact_p1));
  assign err_p1        = res_ext_p1 - exact_ext_p1;
  assign abs_full_p1   = abs_err(ABS_W'(err_p1));
  assign err_mag_p1    = abs_full_p1[ERR_W-1:0];
  assign unused_abs_hi = abs_full_p1[ABS_W-1:ERR_W];

  // Control decode: which pairs are taken, when a run starts, next outputs.
  always_comb begin
    accept   = (state_q == RUN) && valid_i && (acc_cnt_q != n_lat_q);
    last_acc = accept && ((acc_cnt_q + CNT_W'(1)) == n_lat_q);
    clr      = start_i && ((state_q == IDLE) || (state_q == DONE));
    busy_d   = (state_d == RUN) || (state_d == DRAIN);
    done_d   = (state_d == DONE);
  end

  // Next-state logic; a zero-length run skips straight to DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start_i) state_d = (n_samples_i == '0) ? DONE : RUN;
      RUN:        if (last_acc) state_d = DRAIN;
      DRAIN:      if (!any_vld) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // State register with registered busy/done flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_o  <= busy_d;
      done_o  <= done_d;
    end
  end

  // Run length latch and accepted-pair counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_lat_q   <= '0;
      acc_cnt_q <= '0;
    end else if (clr) begin
      n_lat_q   <= n_samples_i;
      acc_cnt_q <= '0;
    end else if (accept) begin
      acc_cnt_q <= acc_cnt_q + CNT_W'(1);
    end
  end

  // Statistics update on every delay-line exit; cleared at run start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_cnt_o   <= '0;
      mismatch_cnt_o <= '0;
      err_sum_o      <= '0;
      err_max_o      <= '0;
    end else if (clr) begin
      sample_cnt_o   <= '0;
      mismatch_cnt_o <= '0;
      err_sum_o      <= '0;
      err_max_o      <= '0;
    end else if (vld_p1) begin
      sample_cnt_o <= sample_cnt_o + CNT_W'(1);
      if (err_p1 != '0) mismatch_cnt_o <= mismatch_cnt_o + CNT_W'(1);
      err_sum_o <= sat_add(err_sum_o, err_mag_p1);
      if (err_mag_p1 > err_max_o) err_max_o <= err_mag_p1;
    end
  end

endmodule

// File: tb/tb_appr_err_monitor.sv
// Bench for appr_err_monitor: behavioural multiplier with selectable error
// injection, and a scoreboard of expected per-sample errors released on the
// cycle each result is due.
module tb_appr_err_monitor;

  localparam int LAT = 2;
  localparam int CW  = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic          valid_i = 1'b0;
  logic [CW-1:0] n_samples_i = '0;
  logic [8:0]    a_i = '0;
  logic [8:0]    b_i = '0;
  logic [17:0]   res_i;

  logic          busy_o, done_o;
  logic [CW-1:0] sample_cnt_o, mismatch_cnt_o;
  logic [47:0]   err_sum_o;
  logic [18:0]   err_max_o;

  logic          s_busy, s_done;
  logic [CW-1:0] s_sample_cnt, s_mismatch_cnt;
  logic [7:0]    s_err_sum;
  logic [18:0]   s_err_max;

  appr_err_monitor #(.MAC_IN_WIDTH(9), .DUT_LATENCY(LAT), .CNT_W(CW), .ACC_W(48)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .n_samples_i(n_samples_i),
    .valid_i(valid_i), .a_i(a_i), .b_i(b_i), .res_i(res_i),
    .busy_o(busy_o), .done_o(done_o), .sample_cnt_o(sample_cnt_o),
    .mismatch_cnt_o(mismatch_cnt_o), .err_sum_o(err_sum_o), .err_max_o(err_max_o)
  );

  appr_err_monitor #(.MAC_IN_WIDTH(9), .DUT_LATENCY(LAT), .CNT_W(CW), .ACC_W(8)) dut_sat (
    .clk(clk), .rst(rst), .start_i(start_i), .n_samples_i(n_samples_i),
    .valid_i(valid_i), .a_i(a_i), .b_i(b_i), .res_i(res_i),
    .busy_o(s_busy), .done_o(s_done), .sample_cnt_o(s_sample_cnt),
    .mismatch_cnt_o(s_mismatch_cnt), .err_sum_o(s_err_sum), .err_max_o(s_err_max)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 0 exact, 1 (-256,-256)->65520, 2 product+1, 3 product+16
  int mode = 0;

  function automatic int model(int a, int b, int m);
    int p;
    p = a * b;
    case (m)
      1: return (a == -256 && b == -256) ? 65520 : p;
      2: return p + 1;
      3: return p + 16;
      default: return p;
    endcase
  endfunction

  logic [17:0] m0, m1;
  always @(posedge clk) begin
    m0 <= 18'(model(int'($signed(a_i)), int'($signed(b_i)), mode));
    m1 <= m0;
  end
  assign res_i = m1;

  typedef struct { int due; int err; } sb_t;
  sb_t sb[$];

  int     errors = 0;
  int     checks = 0;
  longint e_cnt, e_mis, e_sum, e_max;

  task automatic chk(input string tag, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Advance one cycle; release and check every scoreboard entry due now.
  task automatic step();
    sb_t    e;
    longint m;
    @(negedge clk);
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      m = (e.err < 0) ? -e.err : e.err;
      e_cnt++;
      if (e.err != 0) e_mis++;
      e_sum += m;
      if (m > e_max) e_max = m;
      chk("sample_cnt", longint'(sample_cnt_o), e_cnt);
      chk("mismatch_cnt", longint'(mismatch_cnt_o), e_mis);
      chk("err_sum", longint'(err_sum_o), e_sum);
      chk("err_max", longint'(err_max_o), e_max);
      chk("sat_err_sum", longint'(s_err_sum), (e_sum > 255) ? 255 : e_sum);
      chk("sat_sample_cnt", longint'(s_sample_cnt), e_cnt);
    end
  endtask

  task automatic drive_pair(input int a, input int b, input bit acc);
    sb_t e;
    a_i = 9'(a);
    b_i = 9'(b);
    valid_i = 1'b1;
    if (acc) begin
      e.due = cyc + 1 + LAT;
      e.err = model(a, b, mode) - a * b;
      sb.push_back(e);
    end
    step();
    valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      a_i = 9'($urandom);
      b_i = 9'($urandom);
      valid_i = 1'b0;
      step();
    end
  endtask

  task automatic start_run(input int n);
    start_i = 1'b1;
    n_samples_i = CW'(n);
    valid_i = 1'b0;
    e_cnt = 0; e_mis = 0; e_sum = 0; e_max = 0;
    step();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int k);
    k = 0;
    while (!done_o && k < budget) begin
      step();
      k++;
    end
    if (!done_o) chk("done_timeout", longint'(done_o), 1);
  endtask

  task automatic final_chk(input string tag, input longint cnt, input longint mis,
                           input longint sum, input longint mx);
    chk({tag, "_done"}, longint'(done_o), 1);
    chk({tag, "_busy"}, longint'(busy_o), 0);
    chk({tag, "_cnt"}, longint'(sample_cnt_o), cnt);
    chk({tag, "_mis"}, longint'(mismatch_cnt_o), mis);
    chk({tag, "_sum"}, longint'(err_sum_o), sum);
    chk({tag, "_max"}, longint'(err_max_o), mx);
    chk({tag, "_sat_done"}, longint'(s_done), 1);
    chk({tag, "_sat_busy"}, longint'(s_busy), 0);
    chk({tag, "_sat_mis"}, longint'(s_mismatch_cnt), mis);
    chk({tag, "_sat_max"}, longint'(s_err_max), mx);
    chk({tag, "_sb_empty"}, longint'(sb.size()), 0);
  endtask

  task automatic zero_chk(input string tag);
    chk({tag, "_busy"}, longint'(busy_o), 0);
    chk({tag, "_done"}, longint'(done_o), 0);
    chk({tag, "_cnt"}, longint'(sample_cnt_o), 0);
    chk({tag, "_mis"}, longint'(mismatch_cnt_o), 0);
    chk({tag, "_sum"}, longint'(err_sum_o), 0);
    chk({tag, "_max"}, longint'(err_max_o), 0);
    chk({tag, "_sat_sum"}, longint'(s_err_sum), 0);
  endtask

  initial begin
    int k;

    // Reset with inputs toggling
    for (int i = 0; i < 5; i++) begin
      start_i = 1'($urandom);
      valid_i = 1'($urandom);
      n_samples_i = CW'($urandom_range(0, 7));
      a_i = 9'($urandom);
      b_i = 9'($urandom);
      step();
    end
    zero_chk("reset");
    start_i = 1'b0;
    valid_i = 1'b0;
    rst = 1'b0;
    idle(2);
    zero_chk("post_reset");

    // Reset asserted mid-run takes effect immediately
    mode = 0;
    start_run(4);
    drive_pair(1, 2, 1);
    drive_pair(3, 4, 1);
    chk("midrun_busy", longint'(busy_o), 1);
    rst = 1'b1;
    sb.delete();
    #1;
    zero_chk("midrun_reset");
    step();
    rst = 1'b0;
    idle(1);

    // Exact multiplier, four back-to-back pairs
    mode = 0;
    start_run(4);
    chk("t2_busy", longint'(busy_o), 1);
    drive_pair(3, -5, 1);
    drive_pair(-256, -256, 1);
    drive_pair(255, -256, 1);
    drive_pair(0, 7, 1);
    wait_done(10, k);
    chk("t2_done_lat", k, 3);
    final_chk("t2", 4, 0, 0, 0);

    // Single injected error of -16
    mode = 1;
    start_run(1);
    drive_pair(-256, -256, 1);
    wait_done(10, k);
    chk("t3_done_lat", k, 3);
    final_chk("t3", 1, 1, 16, 16);

    // Bubbles in valid_i, +1 error on every sample
    mode = 2;
    start_run(3);
    drive_pair(10, 20, 1);
    idle(2);
    drive_pair(-7, 9, 1);
    idle(1);
    drive_pair(100, -3, 1);
    wait_done(10, k);
    chk("t4_done_lat", k, 3);
    final_chk("t4", 3, 3, 3, 1);

    // Zero-length run
    start_run(0);
    final_chk("t5_zero", 0, 0, 0, 0);

    // start_i during RUN ignored, surplus valid_i ignored
    start_run(3);
    start_i = 1'b1;
    n_samples_i = CW'(1);
    drive_pair(5, 6, 1);
    start_i = 1'b0;
    chk("t5_busy_after_start", longint'(busy_o), 1);
    drive_pair(7, 8, 1);
    drive_pair(9, 10, 1);
    drive_pair(11, 12, 0);
    drive_pair(13, 14, 0);
    wait_done(10, k);
    chk("t5_done_lat", k, 1);
    final_chk("t5", 3, 3, 3, 1);
    idle(3);
    final_chk("t5_hold", 3, 3, 3, 1);

    // Saturation of the 8-bit accumulator
    mode = 3;
    start_run(20);
    for (int i = 0; i < 20; i++)
      drive_pair($urandom_range(0, 511) - 256, $urandom_range(0, 511) - 256, 1);
    wait_done(10, k);
    chk("t6_done_lat", k, 3);
    final_chk("t6", 20, 20, 320, 16);
    chk("t6_sat_sum", longint'(s_err_sum), 255);
    chk("t6_sat_cnt", longint'(s_sample_cnt), 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
